// File: rtl/reg_file.sv
// reg_file: 2**dwidth_RFadd x phit_size register file, one write port, two combinational read ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low clear of every entry (wins over a write)
//   d_in/wr_addr/wen  write data, address, enable
//   rd_addr1/d_out1   read port 1
//   rd_addr2/d_out2   read port 2
module reg_file #(
   parameter int phit_size    = 32,
   parameter int dwidth_RFadd = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [phit_size-1:0]    d_in,
   input  logic [dwidth_RFadd-1:0] wr_addr,
   input  logic                    wen,
   input  logic [dwidth_RFadd-1:0] rd_addr1,
   input  logic [dwidth_RFadd-1:0] rd_addr2,
   output logic [phit_size-1:0]    d_out1,
   output logic [phit_size-1:0]    d_out2
);
   logic [phit_size-1:0] mem [2**dwidth_RFadd];
   always_ff @(posedge clk)
      if (!rst_n)
         for (int i = 0; i < 2**dwidth_RFadd; i++) mem[i] <= '0;
      else if (wen)
         mem[wr_addr] <= d_in;
   // reads come straight from storage: no write-to-read bypass
   assign d_out1 = mem[rd_addr1];
   assign d_out2 = mem[rd_addr2];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file
module tb_reg_file;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] d_in;
   logic [2:0]  wr_addr;
   logic        wen;
   logic [2:0]  rd_addr1;
   logic [2:0]  rd_addr2;
   logic [31:0] d_out1;
   logic [31:0] d_out2;
   int total = 0;
   int bad = 0;

   reg_file dut (
      .clk(clk), .rst_n(rst_n), .d_in(d_in), .wr_addr(wr_addr), .wen(wen),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .d_out1(d_out1), .d_out2(d_out2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic read(input logic [2:0] a1, input logic [2:0] a2);
      rd_addr1 = a1;
      rd_addr2 = a2;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; wen = 1'b0; d_in = '0; wr_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         read(3'(i), 3'(7 - i));
         check("reset_p1", d_out1, 0);
         check("reset_p2", d_out2, 0);
      end
      // fill with 10*i
      for (int i = 0; i < 8; i++) begin
         wen = 1'b1; wr_addr = 3'(i); d_in = 32'(10 * i);
         tick;
      end
      wen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         read(3'(i), 3'(7 - i));
         check("fill_p1", d_out1, 32'(10 * i));
         check("fill_p2", d_out2, 32'(70 - 10 * i));
      end
      // write disabled
      wr_addr = 3'd3; d_in = 32'd999;
      tick;
      read(3'd3, 3'd3);
      check("wen0_p1", d_out1, 32'd30);
      check("wen0_p2", d_out2, 32'd30);
      // read during write, same address on both ports
      read(3'd5, 3'd5);
      wen = 1'b1; wr_addr = 3'd5; d_in = 32'd123;
      #1;
      check("rdw_old_p1", d_out1, 32'd50);
      check("rdw_old_p2", d_out2, 32'd50);
      tick;
      wen = 1'b0;
      check("rdw_new_p1", d_out1, 32'd123);
      check("rdw_new_p2", d_out2, 32'd123);
      read(3'd4, 3'd6);
      check("rdw_hold_p1", d_out1, 32'd40);
      check("rdw_hold_p2", d_out2, 32'd60);
      // mid-sequence reset clears everything
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         read(3'(i), 3'(7 - i));
         check("clr_p1", d_out1, 0);
         check("clr_p2", d_out2, 0);
      end
      // reset beats a simultaneous write
      rst_n = 1'b0; wen = 1'b1; wr_addr = 3'd2; d_in = 32'd77;
      tick;
      rst_n = 1'b1; wen = 1'b0;
      read(3'd2, 3'd2);
      check("rst_vs_wr_p1", d_out1, 0);
      check("rst_vs_wr_p2", d_out2, 0);
      wen = 1'b1;
      tick;
      wen = 1'b0;
      check("resume_p1", d_out1, 32'd77);
      check("resume_p2", d_out2, 32'd77);
      read(3'd1, 3'd3);
      check("resume_oth1", d_out1, 0);
      check("resume_oth2", d_out2, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=%0d exp=%0d", 1, 0);
      $fatal(1, "timeout");
   end
endmodule
